// File: rtl/rt_table_writer.sv
// Runtime routing-row writer: builds a shadow row from config words and publishes it on COMMIT.
// Optional READ command and readback ports are enabled by defining RT_WRITER_READBACK_EN.
module rt_table_writer #(
  parameter int NODES_NUM = 9,
  parameter int ADDR_SIZE = 4,
  parameter int ADDR      = 0,
  parameter int PORTS_NUM = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cfg_valid,
  output logic                          cfg_ready,
  input  logic [2+2*ADDR_SIZE+4-1:0]    cfg_data,
  output logic [NODES_NUM*4-1:0]        table_row,
  output logic                          table_valid,
  output logic                          cfg_err
`ifdef RT_WRITER_READBACK_EN
  ,
  output logic                          rd_valid,
  output logic [3:0]                    rd_data
`endif
);

  localparam int CW    = 2 + 2*ADDR_SIZE + 4;
  localparam int CNT_W = (NODES_NUM > 1) ? $clog2(NODES_NUM) : 1;

  localparam logic [1:0] CMD_WRITE  = 2'b01;
  localparam logic [1:0] CMD_COMMIT = 2'b10;
  localparam logic [1:0] CMD_CLEAR  = 2'b11;
`ifdef RT_WRITER_READBACK_EN
  localparam logic [1:0] CMD_READ   = 2'b00;
`endif

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  state_t                   r_state;
  state_t                   w_next_state;
  logic [CNT_W-1:0]         r_clr_cnt;
  logic [NODES_NUM*4-1:0]   r_shadow;
  logic [NODES_NUM*4-1:0]   r_active;
  logic                     r_table_valid;
  logic                     r_cfg_err;

  logic [1:0]               w_cmd;
  logic [ADDR_SIZE-1:0]     w_node;
  logic [ADDR_SIZE-1:0]     w_dest;
  logic [3:0]               w_port;
  logic [31:0]              w_dest_idx;
  logic                     w_mine;
  logic                     w_accept;
  logic                     w_dest_ok;
  logic                     w_port_ok;
  logic                     w_clr_last;

  assign w_cmd      = cfg_data[CW-1 -: 2];
  assign w_node     = cfg_data[4+2*ADDR_SIZE-1 -: ADDR_SIZE];
  assign w_dest     = cfg_data[4+ADDR_SIZE-1 -: ADDR_SIZE];
  assign w_port     = cfg_data[3:0];
  assign w_dest_idx = 32'(w_dest);
  assign w_mine     = (32'(w_node) == ADDR);
  assign w_accept   = cfg_valid && cfg_ready;
  assign w_dest_ok  = (w_dest_idx < NODES_NUM);
  assign w_port_ok  = (32'(w_port) < PORTS_NUM);
  assign w_clr_last = (32'(r_clr_cnt) == NODES_NUM - 1);

  assign table_row   = r_active;
  assign table_valid = r_table_valid;
  assign cfg_err     = r_cfg_err;

`ifdef RT_WRITER_READBACK_EN
  logic       r_rd_valid;
  logic [3:0] r_rd_data;
  logic [3:0] w_shadow_sel;

  assign rd_valid = r_rd_valid;
  assign rd_data  = r_rd_data;

  always_comb begin
    w_shadow_sel = 4'hF;
    for (int d = 0; d < NODES_NUM; d++) begin
      if (w_dest_idx == d) w_shadow_sel = r_shadow[d*4 +: 4];
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // IDLE is the only state that reads cfg_valid, where ready is known to be high.
  always_comb begin
    w_next_state = r_state;
    cfg_ready    = 1'b0;
    case (r_state)
      S_IDLE: begin
        cfg_ready = 1'b1;
        if (cfg_valid && w_mine && (w_cmd == CMD_CLEAR)) w_next_state = S_CLEAR;
      end
      S_CLEAR: begin
        if (w_clr_last) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_clr_cnt     <= '0;
      r_shadow      <= '1;
      r_active      <= '1;
      r_table_valid <= 1'b0;
      r_cfg_err     <= 1'b0;
`ifdef RT_WRITER_READBACK_EN
      r_rd_valid    <= 1'b0;
      r_rd_data     <= 4'hF;
`endif
    end else begin
      r_cfg_err <= 1'b0;
`ifdef RT_WRITER_READBACK_EN
      r_rd_valid <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (w_accept && w_mine) begin
            case (w_cmd)
              CMD_WRITE: begin
                if (w_dest_ok && w_port_ok) begin
                  for (int d = 0; d < NODES_NUM; d++) begin
                    if (w_dest_idx == d) r_shadow[d*4 +: 4] <= w_port;
                  end
                end else begin
                  r_cfg_err <= 1'b1;
                end
              end
              CMD_COMMIT: begin
                r_active      <= r_shadow;
                r_table_valid <= 1'b1;
              end
              CMD_CLEAR: r_clr_cnt <= '0;
`ifdef RT_WRITER_READBACK_EN
              CMD_READ: begin
                r_rd_valid <= 1'b1;
                if (w_dest_ok) begin
                  r_rd_data <= w_shadow_sel;
                end else begin
                  r_rd_data <= 4'hF;
                  r_cfg_err <= 1'b1;
                end
              end
`endif
              default: ;
            endcase
          end
        end
        S_CLEAR: begin
          // The active row keeps routing traffic while the shadow is swept.
          for (int d = 0; d < NODES_NUM; d++) begin
            if (32'(r_clr_cnt) == d) r_shadow[d*4 +: 4] <= 4'hF;
          end
          r_clr_cnt <= w_clr_last ? '0 : r_clr_cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rt_table_writer.sv
// Directed self-checking bench for rt_table_writer; readback checks compile in
// only when RT_WRITER_READBACK_EN is defined.
module tb_rt_table_writer;

  localparam logic [1:0] CMD_NOP    = 2'b00;
  localparam logic [1:0] CMD_WRITE  = 2'b01;
  localparam logic [1:0] CMD_COMMIT = 2'b10;
  localparam logic [1:0] CMD_CLEAR  = 2'b11;
  localparam logic [35:0] ALL_F     = 36'hF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfgValid = 1'b0;
  logic        cfgReady;
  logic [13:0] cfgData = '0;
  logic [35:0] tableRow;
  logic        tableValid;
  logic        cfgErr;
`ifdef RT_WRITER_READBACK_EN
  logic        rdValid;
  logic [3:0]  rdData;
`endif

  int assertCount = 0;
  int failCount   = 0;
  int lowCount;

  rt_table_writer #(
    .NODES_NUM(9),
    .ADDR_SIZE(4),
    .ADDR(0),
    .PORTS_NUM(4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_valid  (cfgValid),
    .cfg_ready  (cfgReady),
    .cfg_data   (cfgData),
    .table_row  (tableRow),
    .table_valid(tableValid),
    .cfg_err    (cfgErr)
`ifdef RT_WRITER_READBACK_EN
    ,
    .rd_valid   (rdValid),
    .rd_data    (rdData)
`endif
  );

  always #5 clk = ~clk;

  // Presents one word for exactly one rising edge, then samples just after that edge.
  task automatic applyStimulus(input logic [1:0] cmd, input logic [3:0] node,
                               input logic [3:0] dest, input logic [3:0] port);
    cfgData  = {cmd, node, dest, port};
    cfgValid = 1'b1;
    @(posedge clk);
    #1;
    cfgValid = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset held for three cycles
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    checkOutput("reset_row", 64'(tableRow), 64'(ALL_F));
    checkOutput("reset_valid", 64'(tableValid), 64'd0);
    checkOutput("reset_ready", 64'(cfgReady), 64'd1);
    checkOutput("reset_err", 64'(cfgErr), 64'd0);
`ifdef RT_WRITER_READBACK_EN
    checkOutput("reset_rd_valid", 64'(rdValid), 64'd0);
    checkOutput("reset_rd_data", 64'(rdData), 64'hF);
`endif
    tick();
    checkOutput("ready_after_reset", 64'(cfgReady), 64'd1);

    // Program and commit
    applyStimulus(CMD_WRITE, 4'd0, 4'd3, 4'd2);
    checkOutput("row_before_commit_a", 64'(tableRow), 64'(ALL_F));
    checkOutput("err_good_write", 64'(cfgErr), 64'd0);
    applyStimulus(CMD_WRITE, 4'd0, 4'd8, 4'd1);
    checkOutput("row_before_commit_b", 64'(tableRow), 64'(ALL_F));
    checkOutput("valid_before_commit", 64'(tableValid), 64'd0);
    applyStimulus(CMD_COMMIT, 4'd0, 4'd0, 4'd0);
    checkOutput("row_after_commit", 64'(tableRow), 64'h1_FFFF_2FFF);
    checkOutput("valid_after_commit", 64'(tableValid), 64'd1);

    // Words for another node are consumed but ignored
    applyStimulus(CMD_WRITE, 4'd5, 4'd3, 4'd0);
    checkOutput("filter_err", 64'(cfgErr), 64'd0);
    checkOutput("filter_ready", 64'(cfgReady), 64'd1);
    applyStimulus(CMD_CLEAR, 4'd5, 4'd0, 4'd0);
    checkOutput("filter_clear_ready", 64'(cfgReady), 64'd1);
    applyStimulus(CMD_COMMIT, 4'd0, 4'd0, 4'd0);
    checkOutput("filter_row", 64'(tableRow), 64'h1_FFFF_2FFF);

    // Reject: bad port, single-cycle error pulse, shadow untouched
    applyStimulus(CMD_WRITE, 4'd0, 4'd2, 4'd4);
    checkOutput("reject_port_err", 64'(cfgErr), 64'd1);
    tick();
    checkOutput("reject_port_err_clear", 64'(cfgErr), 64'd0);
    applyStimulus(CMD_COMMIT, 4'd0, 4'd0, 4'd0);
    checkOutput("reject_port_row", 64'(tableRow), 64'h1_FFFF_2FFF);

    // Reject: bad dest, followed back-to-back by a good write and a commit
    applyStimulus(CMD_WRITE, 4'd0, 4'd9, 4'd1);
    checkOutput("reject_dest_err", 64'(cfgErr), 64'd1);
    applyStimulus(CMD_WRITE, 4'd0, 4'd5, 4'd3);
    checkOutput("good_after_reject_err", 64'(cfgErr), 64'd0);
    applyStimulus(CMD_COMMIT, 4'd0, 4'd0, 4'd0);
    checkOutput("write_then_commit_row", 64'(tableRow), 64'h1_FF3F_2FFF);
    applyStimulus(CMD_WRITE, 4'd0, 4'd1, 4'hF);
    checkOutput("reject_noroute_err", 64'(cfgErr), 64'd1);

`ifndef RT_WRITER_READBACK_EN
    applyStimulus(CMD_NOP, 4'd0, 4'd3, 4'd1);
    checkOutput("nop_err", 64'(cfgErr), 64'd0);
    applyStimulus(CMD_COMMIT, 4'd0, 4'd0, 4'd0);
    checkOutput("nop_row", 64'(tableRow), 64'h1_FF3F_2FFF);
`endif

    // Clear sweep keeps ready low for nine cycles and leaves the active row alone
    applyStimulus(CMD_CLEAR, 4'd0, 4'd0, 4'd0);
    checkOutput("clear_row_held", 64'(tableRow), 64'h1_FF3F_2FFF);
    lowCount = 0;
    for (int i = 0; i < 20 && !cfgReady; i++) begin
      lowCount++;
      tick();
    end
    checkOutput("clear_ready_low_cycles", 64'(lowCount), 64'd9);
    checkOutput("clear_row_after_sweep", 64'(tableRow), 64'h1_FF3F_2FFF);
    applyStimulus(CMD_COMMIT, 4'd0, 4'd0, 4'd0);
    checkOutput("clear_commit_row", 64'(tableRow), 64'(ALL_F));
    checkOutput("clear_commit_valid", 64'(tableValid), 64'd1);

    // Reset in the middle of a sweep
    applyStimulus(CMD_WRITE, 4'd0, 4'd0, 4'd1);
    applyStimulus(CMD_COMMIT, 4'd0, 4'd0, 4'd0);
    checkOutput("pre_abort_row", 64'(tableRow), 64'hF_FFFF_FFF1);
    applyStimulus(CMD_CLEAR, 4'd0, 4'd0, 4'd0);
    repeat (3) tick();
    checkOutput("mid_sweep_ready", 64'(cfgReady), 64'd0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checkOutput("abort_ready", 64'(cfgReady), 64'd1);
    checkOutput("abort_valid", 64'(tableValid), 64'd0);
    checkOutput("abort_row", 64'(tableRow), 64'(ALL_F));
    tick();
    checkOutput("abort_ready_hold", 64'(cfgReady), 64'd1);

`ifdef RT_WRITER_READBACK_EN
    // Readback of the shadow row
    applyStimulus(CMD_WRITE, 4'd0, 4'd4, 4'd3);
    applyStimulus(CMD_NOP, 4'd0, 4'd4, 4'd0);
    checkOutput("read_valid", 64'(rdValid), 64'd1);
    checkOutput("read_data", 64'(rdData), 64'd3);
    checkOutput("read_err", 64'(cfgErr), 64'd0);
    tick();
    checkOutput("read_valid_pulse", 64'(rdValid), 64'd0);
    applyStimulus(CMD_NOP, 4'd0, 4'd12, 4'd0);
    checkOutput("read_bad_valid", 64'(rdValid), 64'd1);
    checkOutput("read_bad_data", 64'(rdData), 64'hF);
    checkOutput("read_bad_err", 64'(cfgErr), 64'd1);
    applyStimulus(CMD_NOP, 4'd3, 4'd4, 4'd0);
    checkOutput("read_other_node", 64'(rdValid), 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
